// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared shift-add multiplier.
// Grants one requester, issues a start pulse, waits for the completion edge or a timeout, then reports.
module mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b1,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [2*WIDTH-1:0] result,
    output logic               err,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_result,
    output logic               busy
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [TW-1:0]      timer_q;
    logic               owner_q;
    logic               last_owner_q;
    logic               mul_done_prev_q;
    logic               ready_q;
    logic               gnt0_q, gnt1_q;
    logic               done0_q, done1_q;
    logic               mul_start_q;
    logic [WIDTH-1:0]   mul_a_q, mul_b_q;
    logic [2*WIDTH-1:0] result_q;
    logic               err_q;

    logic               winner_d;
    logic               mul_rise;
    logic               timeout_hit;

    // NOTE: every variable driven here gets a default first, so no latch is inferred.
    always_comb begin
        winner_d = 1'b0;
        if (req0 && req1) begin
            winner_d = ~last_owner_q;
        end else if (req1) begin
            winner_d = 1'b1;
        end
    end

    // A level left high by a previous operation must not count as completion.
    assign mul_rise    = mul_done & ~mul_done_prev_q;
    assign timeout_hit = (timer_q == TW'(TIMEOUT - 1));

    // NOTE: all state below uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            owner_q         <= 1'b0;
            last_owner_q    <= 1'b1;
            mul_done_prev_q <= 1'b0;
            ready_q         <= 1'b0;
            gnt0_q          <= 1'b0;
            gnt1_q          <= 1'b0;
            done0_q         <= 1'b0;
            done1_q         <= 1'b0;
            mul_start_q     <= 1'b0;
            mul_a_q         <= '0;
            mul_b_q         <= '0;
            result_q        <= '0;
            err_q           <= 1'b0;
        end else begin
            gnt0_q          <= 1'b0;
            gnt1_q          <= 1'b0;
            done0_q         <= 1'b0;
            done1_q         <= 1'b0;
            mul_start_q     <= 1'b0;
            mul_done_prev_q <= mul_done;
            // Holds off the first grant until the second edge after reset release.
            ready_q         <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (ready_q && (req0 || req1)) begin
                        owner_q <= winner_d;
                        mul_a_q <= winner_d ? a1 : a0;
                        mul_b_q <= winner_d ? b1 : b0;
                        gnt0_q  <= ~winner_d;
                        gnt1_q  <= winner_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_start_q <= 1'b1;
                    timer_q     <= '0;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_rise) begin
                        result_q <= mul_result;
                        err_q    <= 1'b0;
                        state_q  <= S_RESP;
                    end else if (timeout_hit) begin
                        result_q <= '0;
                        err_q    <= 1'b1;
                        state_q  <= S_RESP;
                    end else begin
                        timer_q  <= timer_q + TW'(1);
                    end
                end
                S_RESP: begin
                    done0_q      <= ~owner_q;
                    done1_q      <= owner_q;
                    last_owner_q <= owner_q;
                    state_q      <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign result    = result_q;
    assign err       = err_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed vector table, randomized transactions against a
// transaction-level model, reset-abort and continuous contention sequences.
module tb_mul_arbiter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic               gnt0, gnt1, done0, done1, err, mul_start, busy;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   mul_a, mul_b;
    logic               mul_done = 1'b0;
    logic [2*WIDTH-1:0] mul_result = 16'hDEAD;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .err(err),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_result(mul_result),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Multiplier stand-in: mul_done rises mdl_delay falling edges after the start pulse is seen.
    int                 mdl_delay = 1;
    bit                 mdl_stuck = 1'b0;
    int                 mdl_cnt   = 0;
    logic [2*WIDTH-1:0] mdl_prod  = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt  = 0;
            mul_done = 1'b0;
        end else if (mdl_stuck) begin
            mul_done   = 1'b1;
            mul_result = 16'hBEEF;
        end else if (mul_start) begin
            mul_done = 1'b0;
            mdl_prod = (2*WIDTH)'(mul_a) * (2*WIDTH)'(mul_b);
            mdl_cnt  = mdl_delay;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                mul_done   = 1'b1;
                mul_result = mdl_prod;
            end
        end
    end

    typedef struct {
        logic               r0;
        logic               r1;
        logic [WIDTH-1:0]   a0;
        logic [WIDTH-1:0]   b0;
        logic [WIDTH-1:0]   a1;
        logic [WIDTH-1:0]   b1;
        int                 delay;
        bit                 stuck;
        int                 exp_own;
        logic [2*WIDTH-1:0] exp_res;
        logic               exp_err;
        int                 exp_lat;   // falling edges from grant to done
    } vec_t;

    task automatic wait_gnt(output int who, output int lat);
        who = -1;
        lat = 0;
        for (int i = 1; i <= 20 && who < 0; i++) begin
            @(negedge clk);
            check("gnt_exclusive", 32'(gnt0 & gnt1), 0);
            check("no_done_before_gnt", 32'(done0 | done1), 0);
            if (gnt0) begin
                who = 0; lat = i;
            end else if (gnt1) begin
                who = 1; lat = i;
            end
        end
        if (who < 0) begin
            n_checks++; n_errors++;
            $display("FAIL gnt_timeout: got no grant expected one within 20 cycles");
        end
    endtask

    task automatic wait_done(output int who, output int lat);
        who = -1;
        lat = 0;
        for (int i = 1; i <= TIMEOUT + 10 && who < 0; i++) begin
            @(negedge clk);
            if (done0 && done1) begin
                n_checks++; n_errors++;
                $display("FAIL done_exclusive: got both done high expected one");
            end
            if (done0) begin
                who = 0; lat = i;
            end else if (done1) begin
                who = 1; lat = i;
            end
        end
        if (who < 0) begin
            n_checks++; n_errors++;
            $display("FAIL done_timeout: got no done expected one within %0d cycles", TIMEOUT + 10);
        end
    endtask

    task automatic run_txn(input vec_t v);
        int who, lat;
        if (v.stuck) begin
            mdl_stuck = 1'b1;
            repeat (2) @(negedge clk);
        end else begin
            mdl_stuck = 1'b0;
        end
        mdl_delay = v.delay;
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        req0 = v.r0; req1 = v.r1;
        wait_gnt(who, lat);
        check("gnt_owner", 32'(who), 32'(v.exp_own));
        check("gnt_latency", 32'(lat), 1);
        check("mul_a", 32'(mul_a), 32'(v.exp_own == 1 ? v.a1 : v.a0));
        check("mul_b", 32'(mul_b), 32'(v.exp_own == 1 ? v.b1 : v.b0));
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        check("mul_start", 32'(mul_start), 1);
        check("busy_active", 32'(busy), 1);
        wait_done(who, lat);
        check("done_owner", 32'(who), 32'(v.exp_own));
        check("done_latency", 32'(lat + 1), 32'(v.exp_lat));
        check("result", 32'(result), 32'(v.exp_res));
        check("err", 32'(err), 32'(v.exp_err));
        @(negedge clk);
        check("result_hold", 32'(result), 32'(v.exp_res));
        check("done_single_cycle", 32'(done0 | done1), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    vec_t tbl[8];
    int   rr_last;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected one before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int who, lat;
        vec_t v;

        tbl[0] = '{1, 0,   3,   5,   0,   0,          10, 0, 0,    15, 0, 13};
        tbl[1] = '{0, 1,   0,   0, 255, 255,           3, 0, 1, 65025, 0,  6};
        tbl[2] = '{1, 1,  12,  11,   1,   1,           5, 0, 0,   132, 0,  8};
        tbl[3] = '{1, 1,   0, 200,   9,   9,           1, 0, 1,    81, 0,  4};
        tbl[4] = '{1, 0, 255,   1,   0,   0, TIMEOUT - 1, 0, 0,   255, 0, TIMEOUT + 2};
        tbl[5] = '{0, 1,   0,   0,   7,   8,     TIMEOUT, 0, 1,     0, 1, TIMEOUT + 2};
        tbl[6] = '{1, 0,   4,   4,   0,   0,           1, 1, 0,     0, 1, TIMEOUT + 2};
        tbl[7] = '{1, 0,   6,   7,   0,   0,           2, 0, 0,    42, 0,  5};

        #3;
        check("rst_gnt", 32'({gnt0, gnt1}), 0);
        check("rst_done", 32'({done0, done1}), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_mul_ab", 32'({mul_a, mul_b}), 0);
        check("rst_result", 32'(result), 0);
        check("rst_err", 32'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i]);
        end
        rr_last = tbl[7].exp_own;
        mdl_stuck = 1'b0;

        for (int i = 0; i < 20; i++) begin
            int sel;
            sel = $urandom_range(1, 3);
            v.r0 = sel[0];
            v.r1 = sel[1];
            v.a0 = WIDTH'($urandom); v.b0 = WIDTH'($urandom);
            v.a1 = WIDTH'($urandom); v.b1 = WIDTH'($urandom);
            v.delay = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 1)
                                                  : $urandom_range(1, 8);
            v.stuck = 1'b0;
            if (v.r0 && v.r1) v.exp_own = 1 - rr_last;
            else              v.exp_own = v.r1 ? 1 : 0;
            v.exp_err = (v.delay >= TIMEOUT);
            if (v.exp_err)
                v.exp_res = '0;
            else if (v.exp_own == 1)
                v.exp_res = (2*WIDTH)'(int'(v.a1) * int'(v.b1));
            else
                v.exp_res = (2*WIDTH)'(int'(v.a0) * int'(v.b0));
            v.exp_lat = v.exp_err ? TIMEOUT + 2 : v.delay + 3;
            run_txn(v);
            rr_last = v.exp_own;
        end

        // Abort an operation in WAIT with an asynchronous reset.
        mdl_delay = 20;
        a0 = 9; b0 = 9; req0 = 1'b1;
        wait_gnt(who, lat);
        check("abort_gnt_owner", 32'(who), 0);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_in_wait", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_gnt", 32'({gnt0, gnt1}), 0);
        check("abort_done", 32'({done0, done1}), 0);
        check("abort_mul_start", 32'(mul_start), 0);
        check("abort_mul_ab", 32'({mul_a, mul_b}), 0);
        check("abort_result", 32'(result), 0);
        check("abort_err", 32'(err), 0);

        // Continuous contention from reset release: grants alternate starting with requester 0.
        a0 = 2; b0 = 2; a1 = 7; b1 = 9;
        mdl_delay = 4;
        req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(who, lat);
        check("first_gnt_not_before_second_edge", 32'(lat >= 2), 1);
        rr_last = 1;
        for (int k = 0; k < 4; k++) begin
            int exp_own;
            if (k > 0) begin
                wait_gnt(who, lat);
                check("rr_gnt_gap", 32'(lat), 1);
            end
            exp_own = 1 - rr_last;
            check("rr_gnt_owner", 32'(who), 32'(exp_own));
            check("rr_mul_a", 32'(mul_a), exp_own == 1 ? 7 : 2);
            wait_done(who, lat);
            check("rr_done_owner", 32'(who), 32'(exp_own));
            check("rr_result", 32'(result), exp_own == 1 ? 63 : 4);
            check("rr_err", 32'(err), 0);
            rr_last = exp_own;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand width of the shared shift-add multiplier.
REQ-002 Parameter TIMEOUT, default 64: max cycles in WAIT before abort.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req0, req1  input  1 each  requester k holds high while requesting; operands must stay stable until gntk.
REQ-006 a0, b0, a1, b1  input  WIDTH each  operands of requester k.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: operands of requester k captured.
REQ-008 done0, done1  output  1 each  one-cycle pulse: result and err valid for requester k.
REQ-009 result  output  2*WIDTH  product of the last completed operation.
REQ-010 err  output  1  qualified by donek; 1 = operation timed out, result forced to 0.
REQ-011 mul_start  output  1  one-cycle start pulse to the multiplier control unit.
REQ-012 mul_a, mul_b  output  WIDTH each  registered operands to the multiplier datapath.
REQ-013 mul_done  input  1  multiplier completion level; may remain high across operations.
REQ-014 mul_result  input  2*WIDTH  multiplier product, valid when mul_done rises.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, RESP; one transition per clock maximum.
REQ-017 IDLE: no req -> stay; any req -> pick winner, latch winner's a/b into mul_a/mul_b, pulse gnt of winner, record owner, -> ISSUE.
REQ-018 Arbitration: round-robin; last_owner register, reset value 1, so requester 0 wins first; both req -> winner = requester other than last_owner; single req -> that requester.
REQ-019 ISSUE: mul_start = 1 for exactly this cycle; timer cleared to 0; -> WAIT.
REQ-020 Completion event = rising edge of mul_done (mul_done=1 and registered previous mul_done=0); a level held high from a prior operation is not completion.
REQ-021 WAIT: completion -> capture mul_result into result, err<=0, -> RESP; else timer increments by 1.
REQ-022 WAIT: timer == TIMEOUT-1 with no completion -> result<=0, err<=1, -> RESP; completion in that same cycle takes priority (err=0).
REQ-023 RESP: donek of owner = 1 for this cycle only; last_owner<=owner; -> IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N -> gnt at N+1, mul_start at N+2, done at (cycle after completion edge)+1; minimum 2-cycle gap between consecutive grants (RESP, IDLE).
REQ-025 Requests arriving outside IDLE are held pending, not lost; a req deasserted before grant is dropped silently.
REQ-026 gnt0/gnt1 never both high; done0/done1 never both high; donek only for the granted k.
REQ-027 result and err hold their values until the next RESP.
REQ-028 Timer width ceil(log2(TIMEOUT))+1; no wrap inside WAIT.

Reset
REQ-029 rst_n low -> immediately: state IDLE, gnt0/1=0, done0/1=0, mul_start=0, busy=0, mul_a=mul_b=0, result=0, err=0, timer=0, prev mul_done=0, last_owner=1.
REQ-030 Reset mid-operation abandons the transaction without issuing donek; after release first req is treated as fresh.
REQ-031 After rst_n release, first grant no earlier than the second rising edge.

Verification
REQ-032 Single req0, a0=3, b0=5, multiplier model raises mul_done 10 cycles after start -> gnt0 1 cycle after req, mul_start next cycle, done0 with result=15, err=0.
REQ-033 req0 and req1 high together continuously, a0=2,b0=2,a1=7,b1=9 -> grant order 0,1,0,1; results alternate 4 and 63 on done0/done1.
REQ-034 mul_done held high from before start, never toggles -> no completion; err=1, result=0 on done after TIMEOUT cycles in WAIT.
REQ-035 mul_done rises exactly on timer == TIMEOUT-1 -> err=0, result = mul_result.
REQ-036 rst_n pulsed low during WAIT -> all outputs 0 within the same cycle, no donek, next req0 granted normally.
REQ-037 a=255, b=255, WIDTH=8 -> result=65025, no truncation.
